lbp_hist: RTL and testbench
===========================

// Module: lbp_hist
// PURPOSE
//  Downstream consumer of the LBP stage. Accumulates a 2^CODE_W-bin histogram of
//  the lbp_data codes for one frame. On the LBP stage's finish, streams every bin
//  out over a valid/ready port and clears it, ready for the next frame.
//  Sits between the LBP engine and the host/feature-vector sink.
// PARAMETERS
//  CODE_W  8   LBP code width; number of bins NB = 2**CODE_W
//  CNT_W   14  bin counter width (max 126*126 = 15876 pixels per frame)
//  ADDR_W  14  lbp_addr width (128x128 image)
// PORTS
//  clk         in   1       rising-edge clock
//  reset       in   1       async, active-low; block held in reset while reset==0
//  lbp_valid   in   1       lbp_data/lbp_addr valid this cycle
//  lbp_addr    in   ADDR_W  pixel address of the code (ordering check only)
//  lbp_data    in   CODE_W  LBP code; selects the bin
//  finish      in   1       LBP frame complete (level or pulse)
//  hist_valid  out  1       hist_bin/hist_count valid
//  hist_ready  in   1       sink accepts the beat when hist_valid&&hist_ready
//  hist_bin    out  CODE_W  bin index of the current beat
//  hist_count  out  CNT_W   count for hist_bin
//  hist_done   out  1       one-cycle pulse after the last bin is accepted
//  pix_total   out  CNT_W   codes accumulated this frame (saturating)
//  err         out  1       sticky: drop, saturation or address-order violation
// BEHAVIOUR
//  Reset (reset==0, async): state=IDLE, all bins=0, hist_valid=0, hist_bin=0,
//   hist_count=0, hist_done=0, pix_total=0, err=0, last_addr cleared.
//  FSM: IDLE -> ACCUM on first lbp_valid (that code is counted).
//   ACCUM -> DUMP when finish==1. ACCUM stays while finish==0.
//   DUMP -> DONE on acceptance of bin NB-1. DONE -> IDLE after one cycle.
//   A finish seen in IDLE (empty frame) -> DUMP; all counts are 0.
//  Accumulate (IDLE/ACCUM): each cycle with lbp_valid, bin[lbp_data] += 1 and
//   pix_total += 1, both visible next cycle. Back-to-back identical codes count
//   every cycle; no stalls and no lost increments.
//  Saturation: a bin at 2**CNT_W-1 holds its value and sets err. Same for pix_total.
//  Order check: within a frame, lbp_addr must strictly increase. A non-increasing
//   lbp_addr is still counted and sets err.
//  Simultaneous lbp_valid and finish in ACCUM: the code is counted first, then
//   state moves to DUMP; its bin reflects the increment.
//  DUMP: hist_valid=1. hist_bin starts at 0. hist_count = bin[hist_bin], registered.
//   Outputs hold stable while hist_ready==0.
//   On acceptance: bin[hist_bin] is cleared and hist_bin increments (no wrap).
//   Bin NB-1 accepted -> hist_valid=0 the next cycle, hist_done=1 for exactly one
//   cycle (DONE).
//  lbp_valid during DUMP/DONE: the code is dropped and err is set.
//  In DONE: pix_total cleared, last_addr cleared, hist_bin returns to 0.
//   err persists until reset.
//  finish held high into IDLE after DONE: no new dump until a code has been
//   accumulated. A new frame requires lbp_valid before finish is re-armed.
//   finish is re-armed only after a low level or a new lbp_valid.
//  Reset mid-DUMP: all bins cleared, outputs return to reset values immediately.
//  Latency: finish -> first hist_valid = 1 cycle.
//   Full dump = NB cycles with hist_ready held high.
// TESTING
//  T1 codes 5,5,5,200 on consecutive cycles, then finish, hist_ready=1 ->
//     bin5=3, bin200=1, all others 0, pix_total=4, hist_done after 256 beats.
//  T2 full 126x126 frame, all codes 0x00 -> bin0=15876, rest 0, err=0.
//  T3 same as T1 with hist_ready toggling 1/0 every cycle -> identical data,
//     no duplicate or skipped hist_bin, beats held stable while not ready.
//  T4 lbp_valid with code 7 on the same cycle as finish -> bin7 includes it.
//     Then lbp_valid during DUMP -> err=1, dump contents unchanged.
//  T5 lbp_addr sequence 10,11,11 -> err=1, all three codes counted.
//  T6 reset=0 at beat 100 of a dump -> all outputs at reset values.
//     Next frame with code 9 x2 -> bin9=2, bin0..8=0.

Source files
------------

// File: rtl/lbp_hist.sv
// lbp_hist: per-frame histogram of LBP codes.
//
// Each valid code increments the bin that the code selects. When finish arrives,
// every bin is streamed out in order 0..NB-1 over a valid/ready port. Each bin is
// cleared as its beat is accepted, so the block is ready for the next frame.
//
// Ports
//   clk, reset          rising-edge clock, async active-low reset
//   lbp_valid/addr/data incoming code stream (addr is used only for the order check)
//   finish              frame complete (level or pulse)
//   hist_valid/ready    output handshake; hist_bin/hist_count carry one beat
//   hist_done           one-cycle pulse after bin NB-1 has been accepted
//   pix_total           number of codes accumulated this frame (saturating)
//   err                 sticky: drop, saturation or address-order violation
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | no code yet this frame; the first valid code is counted
// S_ACCUM | counting codes until finish
// S_DUMP  | streaming bins; each accepted bin is cleared
// S_DONE  | one-cycle hist_done; per-frame bookkeeping is cleared
module lbp_hist #(
    parameter int CODE_W = 8,
    parameter int CNT_W  = 14,
    parameter int ADDR_W = 14
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              lbp_valid,
    input  logic [ADDR_W-1:0] lbp_addr,
    input  logic [CODE_W-1:0] lbp_data,
    input  logic              finish,
    output logic              hist_valid,
    input  logic              hist_ready,
    output logic [CODE_W-1:0] hist_bin,
    output logic [CNT_W-1:0]  hist_count,
    output logic              hist_done,
    output logic [CNT_W-1:0]  pix_total,
    output logic              err
);

    localparam int NB = 2**CODE_W;
    localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
    localparam logic [CNT_W-1:0]  CNT_ONE  = 1;
    localparam logic [CODE_W-1:0] LAST_BIN = '1;
    localparam logic [CODE_W-1:0] BIN_ONE  = 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ACCUM = 2'd1;
    localparam logic [1:0] S_DUMP  = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]        state_q, state_d;
    logic [CNT_W-1:0]  bins_q [NB];
    logic [CNT_W-1:0]  bins_d [NB];
    logic [CODE_W-1:0] hist_bin_q, hist_bin_d;
    logic [CNT_W-1:0]  hist_count_q, hist_count_d;
    logic [CNT_W-1:0]  pix_total_q, pix_total_d;
    logic              err_q, err_d;
    logic [ADDR_W-1:0] last_addr_q, last_addr_d;
    logic              have_addr_q, have_addr_d;
    logic              armed_q, armed_d;
    logic              accum;

    always_comb begin
        state_d     = state_q;
        hist_bin_d  = hist_bin_q;
        pix_total_d = pix_total_q;
        err_d       = err_q;
        last_addr_d = last_addr_q;
        have_addr_d = have_addr_q;
        armed_d     = armed_q;
        for (int i = 0; i < NB; i++) begin
            bins_d[i] = bins_q[i];
        end

        accum = lbp_valid && (state_q == S_IDLE || state_q == S_ACCUM);

        if (accum) begin
            if (bins_q[lbp_data] == CNT_MAX) begin
                err_d = 1'b1;
            end else begin
                bins_d[lbp_data] = bins_q[lbp_data] + CNT_ONE;
            end
            if (pix_total_q == CNT_MAX) begin
                err_d = 1'b1;
            end else begin
                pix_total_d = pix_total_q + CNT_ONE;
            end
            // The first code of a frame has no predecessor to compare against.
            if (have_addr_q && lbp_addr <= last_addr_q) begin
                err_d = 1'b1;
            end
            last_addr_d = lbp_addr;
            have_addr_d = 1'b1;
        end

        if (lbp_valid && (state_q == S_DUMP || state_q == S_DONE)) begin
            err_d = 1'b1;
        end

        // A finish level left high after a dump must not start a second dump
        // of an empty frame; it re-arms once it drops.
        if (!finish) begin
            armed_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (finish && (armed_q || lbp_valid)) begin
                    state_d = S_DUMP;
                end else if (lbp_valid) begin
                    state_d = S_ACCUM;
                end
            end
            S_ACCUM: begin
                if (finish) begin
                    state_d = S_DUMP;
                end
            end
            S_DUMP: begin
                if (hist_ready) begin
                    bins_d[hist_bin_q] = '0;
                    if (hist_bin_q == LAST_BIN) begin
                        state_d = S_DONE;
                    end else begin
                        hist_bin_d = hist_bin_q + BIN_ONE;
                    end
                end
            end
            default: begin
                state_d     = S_IDLE;
                pix_total_d = '0;
                last_addr_d = '0;
                have_addr_d = 1'b0;
                hist_bin_d  = '0;
            end
        endcase

        if (state_d == S_DUMP && state_q != S_DUMP) begin
            armed_d = 1'b0;
        end

        // Reading the next-state array means a code counted on the finish cycle
        // is already included in the first beat.
        hist_count_d = (state_d == S_DUMP) ? bins_d[hist_bin_d] : '0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            hist_bin_q   <= '0;
            hist_count_q <= '0;
            pix_total_q  <= '0;
            err_q        <= 1'b0;
            last_addr_q  <= '0;
            have_addr_q  <= 1'b0;
            armed_q      <= 1'b1;
            for (int i = 0; i < NB; i++) begin
                bins_q[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            hist_bin_q   <= hist_bin_d;
            hist_count_q <= hist_count_d;
            pix_total_q  <= pix_total_d;
            err_q        <= err_d;
            last_addr_q  <= last_addr_d;
            have_addr_q  <= have_addr_d;
            armed_q      <= armed_d;
            for (int i = 0; i < NB; i++) begin
                bins_q[i] <= bins_d[i];
            end
        end
    end

    assign hist_valid = (state_q == S_DUMP);
    assign hist_done  = (state_q == S_DONE);
    assign hist_bin   = hist_bin_q;
    assign hist_count = hist_count_q;
    assign pix_total  = pix_total_q;
    assign err        = err_q;

endmodule

// File: tb/tb_lbp_hist.sv
// Scoreboard bench for lbp_hist. Stimulus updates a plain-array histogram model
// and pushes the expected dump when finish is issued; a negedge monitor pops
// and compares every accepted beat.
module tb_lbp_hist;
    localparam int CODE_W  = 8;
    localparam int CNT_W   = 14;
    localparam int ADDR_W  = 14;
    localparam int NB      = 256;
    localparam int CNT_MAX = 16383;

    logic              clk = 1'b0;
    logic              reset;
    logic              lbp_valid;
    logic [ADDR_W-1:0] lbp_addr;
    logic [CODE_W-1:0] lbp_data;
    logic              finish;
    logic              hist_valid;
    logic              hist_ready;
    logic [CODE_W-1:0] hist_bin;
    logic [CNT_W-1:0]  hist_count;
    logic              hist_done;
    logic [CNT_W-1:0]  pix_total;
    logic              err;

    always #5 clk = ~clk;

    lbp_hist #(.CODE_W(CODE_W), .CNT_W(CNT_W), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .reset(reset), .lbp_valid(lbp_valid), .lbp_addr(lbp_addr),
        .lbp_data(lbp_data), .finish(finish), .hist_valid(hist_valid),
        .hist_ready(hist_ready), .hist_bin(hist_bin), .hist_count(hist_count),
        .hist_done(hist_done), .pix_total(pix_total), .err(err)
    );

    typedef struct {
        int bin;
        int count;
        int total;
    } beat_t;

    beat_t exp_q[$];
    int    checks = 0;
    int    errors = 0;

    int m_hist[NB];
    int m_total;
    bit m_err;
    bit m_have;
    int m_last;

    int beats;
    bit done_flag;
    int done_wait;
    bit held_valid;
    int held_bin;
    int held_count;

    function automatic void check(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endfunction

    function automatic void model_clear_frame();
        for (int b = 0; b < NB; b++) m_hist[b] = 0;
        m_total = 0;
        m_have  = 0;
        m_last  = 0;
    endfunction

    function automatic void model_accept(int a, int c);
        if (m_have && a <= m_last) m_err = 1;
        m_last = a;
        m_have = 1;
        if (m_hist[c] >= CNT_MAX) m_err = 1;
        else m_hist[c]++;
        if (m_total >= CNT_MAX) m_err = 1;
        else m_total++;
    endfunction

    function automatic void model_push();
        beat_t e;
        for (int b = 0; b < NB; b++) begin
            e.bin   = b;
            e.count = m_hist[b];
            e.total = m_total;
            exp_q.push_back(e);
        end
        model_clear_frame();
    endfunction

    always @(negedge clk) begin
        beat_t e;
        if (done_wait == 1) begin
            check("done_pulse", int'(hist_done), 1);
            check("valid_after_last", int'(hist_valid), 0);
            done_wait = 2;
        end else if (done_wait == 2) begin
            check("done_one_cycle", int'(hist_done), 0);
            done_wait = 0;
            done_flag = 1;
        end else if (hist_done) begin
            check("spurious_done", int'(hist_done), 0);
        end

        if (hist_valid) begin
            if (held_valid) begin
                check("hold_bin", int'(hist_bin), held_bin);
                check("hold_count", int'(hist_count), held_count);
            end
            if (hist_ready) begin
                held_valid = 0;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_beat: got bin %0d, expected no beat", hist_bin);
                end else begin
                    e = exp_q.pop_front();
                    check("beat_bin", int'(hist_bin), e.bin);
                    check($sformatf("bin%0d_count", e.bin), int'(hist_count), e.count);
                    if (e.bin == 0) check("pix_total", int'(pix_total), e.total);
                    beats++;
                    if (e.bin == NB - 1) done_wait = 1;
                end
            end else begin
                held_valid = 1;
                held_bin   = hist_bin;
                held_count = hist_count;
            end
        end else begin
            held_valid = 0;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(int a, int c);
        lbp_valid = 1'b1;
        lbp_addr  = ADDR_W'(a);
        lbp_data  = CODE_W'(c);
        model_accept(a, c);
        step();
        lbp_valid = 1'b0;
    endtask

    // mode 0: ready always high, 1: toggling, 2: random.
    task automatic dump(int mode, bit with_code, int ca, int cc, bit drop);
        int cyc;
        cyc = 0;
        if (with_code) begin
            lbp_valid = 1'b1;
            lbp_addr  = ADDR_W'(ca);
            lbp_data  = CODE_W'(cc);
            model_accept(ca, cc);
        end
        model_push();
        finish     = 1'b1;
        done_flag  = 0;
        hist_ready = (mode == 0);
        step();
        finish    = 1'b0;
        lbp_valid = 1'b0;
        while (!done_flag && cyc < 3000) begin
            case (mode)
                0:       hist_ready = 1'b1;
                1:       hist_ready = ~hist_ready;
                default: hist_ready = 1'($urandom_range(0, 1));
            endcase
            if (drop && cyc == 0) begin
                lbp_valid = 1'b1;
                lbp_addr  = ADDR_W'(ca + 1);
                lbp_data  = CODE_W'(cc);
                m_err     = 1;
            end
            step();
            lbp_valid = 1'b0;
            cyc++;
        end
        check("dump_completed", int'(done_flag), 1);
        check("queue_drained", exp_q.size(), 0);
        hist_ready = 1'b0;
    endtask

    task automatic check_reset_outputs(string tag);
        check({tag, "_hist_valid"}, int'(hist_valid), 0);
        check({tag, "_hist_bin"}, int'(hist_bin), 0);
        check({tag, "_hist_count"}, int'(hist_count), 0);
        check({tag, "_hist_done"}, int'(hist_done), 0);
        check({tag, "_pix_total"}, int'(pix_total), 0);
        check({tag, "_err"}, int'(err), 0);
    endtask

    initial begin
        int n;
        int a;
        int c;
        int cyc;

        reset      = 1'b0;
        lbp_valid  = 1'b0;
        lbp_addr   = '0;
        lbp_data   = '0;
        finish     = 1'b0;
        hist_ready = 1'b0;
        beats      = 0;
        done_flag  = 0;
        done_wait  = 0;
        held_valid = 0;
        m_err      = 0;
        model_clear_frame();
        repeat (3) step();
        check_reset_outputs("reset");
        reset = 1'b1;
        step();

        // T1
        send(0, 5); send(1, 5); send(2, 5); send(3, 200);
        dump(0, 0, 0, 0, 0);
        check("t1_err", int'(err), int'(m_err));

        // T3: same data, ready toggling
        send(0, 5); send(1, 5); send(2, 5); send(3, 200);
        dump(1, 0, 0, 0, 0);

        // T2: full 126x126 frame of code 0
        for (int i = 0; i < 15876; i++) send(i, 0);
        dump(0, 0, 0, 0, 0);
        check("t2_err", int'(err), int'(m_err));

        // Randomized frames with gaps and random backpressure
        for (int f = 0; f < 5; f++) begin
            n = $urandom_range(20, 400);
            a = $urandom_range(0, 50);
            for (int i = 0; i < n; i++) begin
                if ($urandom_range(0, 3) == 0) step();
                c = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 7) : $urandom_range(0, 255);
                send(a, c);
                a += $urandom_range(1, 3);
            end
            dump(2, 0, 0, 0, 0);
        end
        check("random_err", int'(err), int'(m_err));

        // T5: non-increasing address is counted and flagged
        send(10, 3); send(11, 4); send(11, 5);
        dump(0, 0, 0, 0, 0);
        check("t5_err", int'(err), int'(m_err));

        // T4: code 7 with finish, then a dropped code during the dump
        send(0, 1);
        dump(2, 1, 1, 7, 1);
        check("t4_err", int'(err), int'(m_err));

        // Saturation of a bin and of pix_total
        for (int i = 0; i < 16384; i++) send(i, 42);
        dump(0, 0, 0, 0, 0);
        check("sat_err", int'(err), int'(m_err));

        // T6: reset at beat 100 of a dump
        send(0, 9); send(1, 17); send(2, 250);
        model_push();
        finish    = 1'b1;
        done_flag = 0;
        step();
        finish     = 1'b0;
        hist_ready = 1'b1;
        beats      = 0;
        cyc        = 0;
        while (beats < 100 && cyc < 1000) begin
            step();
            cyc++;
        end
        check("t6_reached_beat100", int'(beats >= 100), 1);
        reset = 1'b0;
        #1;
        check_reset_outputs("t6_reset");
        exp_q.delete();
        m_err = 0;
        model_clear_frame();
        hist_ready = 1'b0;
        repeat (2) step();
        reset = 1'b1;
        step();
        send(0, 9); send(1, 9);
        dump(0, 0, 0, 0, 0);
        check("t6_err", int'(err), int'(m_err));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
